ts_chan_tx_33b: RTL and testbench
=================================

# ts_chan_tx_33b

Per-channel packet source feeding one input of the 4-to-1 33-bit channel arbiter. It buffers complete packets of 33-bit words (bit 32 = packet-start marker, bits 31:0 = payload) from an upstream splitter stage. For each buffered packet it drives the arbiter's request/ack/stream handshake: raise valid, wait for a one-cycle rd_ack, then stream the packet. One instance sits in front of each of the arbiter's four channel inputs.

## Interface
- ADDR_W, 8: log2 of word-buffer depth (256 words).
- MAX_PKT_WORDS, 47: maximum stored words per packet (one 188-byte TS packet).
- LEN_DEPTH, 8: number of committed-packet length entries.
- GAP_CYCLES, 1: minimum cycles data_out_valid is held low between packets (≥1).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- data_in  in  33  upstream word.
- data_in_valid  in  1  high for each word of a packet; one contiguous run = one packet.
- rd_ack  in  1  one-cycle grant pulse from the arbiter.
- data_out  out  33  word to the arbiter.
- data_out_valid  out  1  request, then packet framing.
- buf_empty  out  1  no committed packet pending and the output FSM is in IDLE.
- drop_cnt  out  16  saturating count of rejected or truncated packets.

## Operation
- Write side, packet start: the first cycle data_in_valid is high after a low cycle.
  - Accept the packet if free words ≥ MAX_PKT_WORDS and fewer than LEN_DEPTH lengths are committed.
  - Otherwise discard all words of the packet and increment drop_cnt.
- Accepted packet:
  - Words are written in order.
  - Words beyond MAX_PKT_WORDS are discarded. The packet is still committed with MAX_PKT_WORDS words, and drop_cnt increments once.
  - Commit happens on the first cycle data_in_valid is low: push the length into the length FIFO.
- Free-word accounting includes the uncommitted in-progress packet. Buffer space is released as each word is read out.
- Output FSM, 2-bit states:
  - IDLE: if a length is committed, go to REQ.
  - REQ: data_out_valid=1, data_out=0. Stay until rd_ack is sampled high, then go to SEND.
  - SEND: present one word per cycle. After the last word, go to GAP.
  - GAP: data_out_valid=0 for GAP_CYCLES cycles, then go to IDLE.
- rd_ack sampled in any state other than REQ is ignored.
- data_out_valid never drops within a packet. The arbiter treats the first low cycle as end of packet.
- Read and write of the buffer may occur in the same cycle. Pointers wrap modulo 2^ADDR_W.
- drop_cnt holds at 16'hFFFF.

## Timing
- Reset (reset=0 at posedge): data_out=0, data_out_valid=0, drop_cnt=0, buf_empty=1, FSM=IDLE.
  - Pointers, length FIFO and any in-progress packet are cleared; all buffered data is lost.
  - A packet whose input run straddles reset deassertion is dropped without counting (no clean start seen).
- Commit to request: the first cycle a length is committed, the FSM is in IDLE. data_out_valid rises on the following cycle.
- Grant to data, with rd_ack high in cycle t (sampled at the edge ending t):
  - data_out = word0 and data_out_valid = 1 in cycle t+1.
  - word k is presented in cycle t+1+k.
  - data_out_valid = 0 in cycle t+1+N.
- The buffer RAM has 1-cycle read latency. Word0 is prefetched during REQ so no bubble appears after grant.
- Back-to-back packets: the next REQ begins GAP_CYCLES cycles after the last word is presented.
- Simultaneous events:
  - Commit and read of another packet in the same cycle: both proceed.
  - A packet start on the same cycle a slot frees: the acceptance check uses free space before the release (conservative).

## Structure
- Shared package ts_chan_pkg holds:
  - WORD_W=33 and SOP_BIT=32.
  - Default MAX_PKT_WORDS.
  - Output FSM state constants (IDLE, REQ, SEND, GAP).
- Sub-module sdp_ram_33b: simple dual-port RAM with registered read and parameterised ADDR_W. Instantiated once.
- Length FIFO: small register array inside the top module.

## Test plan
- Single 47-word packet; rd_ack 5 cycles after valid rises:
  - words appear starting the cycle after rd_ack, in order, contiguous, 47 cycles;
  - valid then low; buf_empty returns to 1.
- Two 47-word packets input back-to-back, rd_ack 3 cycles after each request:
  - two correct bursts separated by ≥ GAP_CYCLES low cycles;
  - drop_cnt=0.
- Six 47-word packets with rd_ack withheld (256-word buffer):
  - five accepted, sixth dropped, drop_cnt=1;
  - after acks, exactly five packets are output.
- 60-word input packet:
  - output burst is 47 words (first 47 inputs);
  - drop_cnt=1.
- Reset asserted mid-SEND at word 20:
  - next cycle data_out_valid=0, data_out=0, buf_empty=1;
  - no further words are emitted.
- rd_ack pulse while in IDLE or SEND:
  - no state change and no duplicated or skipped word.

Source files
------------

// File: rtl/ts_chan_pkg.sv
// Shared definitions for the per-channel packet source (ts_chan_tx_33b).
// Holds the word layout, the default packet size and the output FSM states.
package ts_chan_pkg;

  localparam int WORD_W            = 33;  // bit 32 = packet-start marker
  localparam int SOP_BIT           = 32;
  localparam int MAX_PKT_WORDS_DEF = 47;  // one 188-byte TS packet

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/ts_chan_tx_33b_if.sv
// Word stream interface of ts_chan_tx_33b.
//   data_in / data_in_valid   : packet words from the upstream splitter
//   rd_ack                    : one-cycle grant pulse from the arbiter
//   data_out / data_out_valid : request then packet framing to the arbiter
// master = the channel source, slave = its environment (splitter + arbiter).
interface ts_chan_tx_33b_if;
  import ts_chan_pkg::*;

  logic [WORD_W-1:0] data_in;
  logic              data_in_valid;
  logic              rd_ack;
  logic [WORD_W-1:0] data_out;
  logic              data_out_valid;

  modport master (
    input  data_in, data_in_valid, rd_ack,
    output data_out, data_out_valid
  );

  modport slave (
    output data_in, data_in_valid, rd_ack,
    input  data_out, data_out_valid
  );

endinterface

// File: rtl/sdp_ram_33b.sv
// Simple dual-port word RAM, one write port and one registered read port.
//   clk     : clock
//   wr_en   : write strobe, wr_addr / wr_data : write port
//   rd_addr : read address, rd_data : mem[rd_addr] one cycle later
// A read of the address being written in the same cycle returns old data.
module sdp_ram_33b
  import ts_chan_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ts_chan_tx_33b.sv
// Per-channel packet source in front of one input of the 4-to-1 arbiter.
// Buffers complete packets, then for each one raises a request, waits for
// the rd_ack grant and streams the packet with no bubbles.
//   clk, reset : clock, synchronous active-low reset
//   bus        : word stream interface (master side)
//   buf_empty  : no committed packet pending and output FSM idle
//   drop_cnt   : saturating count of rejected or truncated packets
module ts_chan_tx_33b
  import ts_chan_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int MAX_PKT_WORDS = MAX_PKT_WORDS_DEF,
  parameter int LEN_DEPTH     = 8,
  parameter int GAP_CYCLES    = 1
) (
  input  logic               clk,
  input  logic               reset,
  ts_chan_tx_33b_if.master   bus,
  output logic               buf_empty,
  output logic [15:0]        drop_cnt
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int USED_W = ADDR_W + 1;
  localparam int LEN_W  = $clog2(MAX_PKT_WORDS + 1);
  localparam int LQ_AW  = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int LC_W   = $clog2(LEN_DEPTH + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [USED_W-1:0] USED_MAX = USED_W'(DEPTH - MAX_PKT_WORDS);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_PKT_WORDS);
  localparam logic [LC_W-1:0]   LQ_FULL  = LC_W'(LEN_DEPTH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [LQ_AW-1:0] lq_inc(input logic [LQ_AW-1:0] p);
    return (p == LQ_AW'(LEN_DEPTH - 1)) ? '0 : p + LQ_AW'(1);
  endfunction

  tx_state_t          state;
  logic               in_prev, wr_active, wr_trunc;
  logic [LEN_W-1:0]   wr_len, remaining;
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [USED_W-1:0]  used;
  logic [LEN_W-1:0]   len_q [LEN_DEPTH];
  logic [LQ_AW-1:0]   lq_wr, lq_rd;
  logic [LC_W-1:0]    lq_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [WORD_W-1:0]  rd_word_p1;

  logic pkt_start, accept, wr_room, wr_en, commit, trunc_ev, drop_ev;
  logic pop, rd_adv;

  // Acceptance uses occupancy before this cycle's read release.
  assign pkt_start = bus.data_in_valid & ~in_prev;
  assign accept    = (used <= USED_MAX) && (lq_cnt < LQ_FULL);
  assign wr_room   = wr_len < LEN_MAX;
  assign wr_en     = bus.data_in_valid & ((pkt_start & accept) | (wr_active & wr_room));
  assign commit    = wr_active & ~bus.data_in_valid;
  assign trunc_ev  = wr_active & bus.data_in_valid & ~wr_room & ~wr_trunc;
  assign drop_ev   = (pkt_start & ~accept) | trunc_ev;

  assign pop        = (state == REQ) & bus.rd_ack;
  assign rd_adv     = pop | ((state == SEND) && (remaining != '0));
  // RAM is addressed with the next pointer so its registered output always
  // holds the word at the current read pointer.
  assign rd_ptr_nxt = rd_adv ? rd_ptr + ADDR_W'(1) : rd_ptr;

  assign buf_empty  = (lq_cnt == '0) && (state == IDLE);

  sdp_ram_33b #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr_nxt),
    .rd_data (rd_word_p1)
  );

  // Write side: packet capture, length FIFO and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // Sampling valid here makes a run that straddles reset look unstarted.
      in_prev   <= bus.data_in_valid;
      wr_active <= 1'b0;
      wr_trunc  <= 1'b0;
      wr_ptr    <= '0;
      used      <= '0;
      lq_wr     <= '0;
      lq_rd     <= '0;
      lq_cnt    <= '0;
      drop_cnt  <= '0;
    end else begin
      in_prev <= bus.data_in_valid;
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        wr_len <= pkt_start ? LEN_W'(1) : wr_len + LEN_W'(1);
      end
      if (pkt_start) begin
        wr_active <= accept;
        wr_trunc  <= 1'b0;
      end
      if (trunc_ev) wr_trunc <= 1'b1;
      if (commit) begin
        len_q[lq_wr] <= wr_len;
        lq_wr        <= lq_inc(lq_wr);
        wr_active    <= 1'b0;
      end
      if (pop) lq_rd <= lq_inc(lq_rd);
      case ({commit, pop})
        2'b10:   lq_cnt <= lq_cnt + LC_W'(1);
        2'b01:   lq_cnt <= lq_cnt - LC_W'(1);
        default: lq_cnt <= lq_cnt;
      endcase
      case ({wr_en, rd_adv})
        2'b10:   used <= used + USED_W'(1);
        2'b01:   used <= used - USED_W'(1);
        default: used <= used;
      endcase
      if (drop_ev) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Read side: output FSM with registered outputs; RAM output is stage p1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
      rd_ptr             <= '0;
      gap_cnt            <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      case (state)
        IDLE: if (lq_cnt != '0) begin
          state              <= REQ;
          bus.data_out_valid <= 1'b1;
          bus.data_out       <= '0;
        end
        REQ: if (bus.rd_ack) begin
          state        <= SEND;
          bus.data_out <= rd_word_p1;
          remaining    <= len_q[lq_rd] - LEN_W'(1);
        end
        SEND: if (remaining != '0) begin
          bus.data_out <= rd_word_p1;
          remaining    <= remaining - LEN_W'(1);
        end else begin
          state              <= GAP;
          bus.data_out_valid <= 1'b0;
          bus.data_out       <= '0;
          gap_cnt            <= GAP_W'(GAP_CYCLES - 1);
        end
        GAP: if (gap_cnt == '0) begin
          // Go straight to the next request so the gap is exactly GAP_CYCLES.
          if (lq_cnt != '0) begin
            state              <= REQ;
            bus.data_out_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end else begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_chan_tx_33b.sv
// Directed bench for ts_chan_tx_33b: inputs are driven and outputs sampled
// 1 time unit after each rising edge.
module tb_ts_chan_tx_33b;
  import ts_chan_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        buf_empty;
  logic [15:0] drop_cnt;
  int          n_chk = 0;
  int          n_pass = 0;

  ts_chan_tx_33b_if bus ();

  ts_chan_tx_33b dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .buf_empty (buf_empty),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] wd(input int p, input int k);
    return {(k == 0), 16'(p), 16'(k)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one packet of n words, then one low cycle so it commits.
  task automatic send_pkt(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      bus.data_in_valid = 1'b1;
      bus.data_in       = wd(p, k);
      step();
    end
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    step();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.data_out_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({"req_", tag}, {bus.data_out_valid, bus.data_out}, {1'b1, 33'h0});
  endtask

  // Hold the request d cycles, then pulse rd_ack for one cycle.
  task automatic grant(input string tag, input int d);
    for (int i = 0; i < d; i++) begin
      step();
      chk({"hold_", tag}, {bus.data_out_valid, bus.data_out}, {1'b1, 33'h0});
    end
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
  endtask

  task automatic words(input string tag, input int p, input int from, input int to);
    for (int k = from; k < to; k++) begin
      chk({"word_", tag}, {bus.data_out_valid, bus.data_out}, {1'b1, wd(p, k)});
      step();
    end
  endtask

  initial begin
    int hits;
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    bus.rd_ack        = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_valid", bus.data_out_valid, 1'b0);
    chk("rst_data", bus.data_out, 33'h0);
    chk("rst_empty", buf_empty, 1'b1);
    chk("rst_drop", drop_cnt, 16'h0);
    reset = 1'b1;
    step();

    // Single packet, ack 5 cycles after request
    send_pkt(1, 47);
    chk("t1_commit_valid", bus.data_out_valid, 1'b0);
    chk("t1_commit_empty", buf_empty, 1'b0);
    step();
    chk("t1_req_rise", {bus.data_out_valid, bus.data_out}, {1'b1, 33'h0});
    grant("t1", 5);
    words("t1", 1, 0, 47);
    chk("t1_end", bus.data_out_valid, 1'b0);
    step();
    chk("t1_empty", buf_empty, 1'b1);

    // Two back-to-back packets, ack 3 cycles after each request
    send_pkt(2, 47);
    send_pkt(3, 47);
    wait_req("t2a");
    grant("t2a", 3);
    words("t2a", 2, 0, 47);
    chk("t2a_end", bus.data_out_valid, 1'b0);
    step();
    chk("t2_gap_req", {bus.data_out_valid, bus.data_out}, {1'b1, 33'h0});
    grant("t2b", 3);
    words("t2b", 3, 0, 47);
    chk("t2b_end", bus.data_out_valid, 1'b0);
    step();
    chk("t2_empty", buf_empty, 1'b1);
    chk("t2_drop", drop_cnt, 16'h0);

    // Six packets without grants: the sixth does not fit
    for (int p = 10; p < 16; p++) send_pkt(p, 47);
    chk("t3_drop", drop_cnt, 16'h1);
    for (int p = 10; p < 15; p++) begin
      wait_req("t3");
      grant("t3", 2);
      words("t3", p, 0, 47);
      chk("t3_end", bus.data_out_valid, 1'b0);
    end
    repeat (5) step();
    chk("t3_no_sixth", bus.data_out_valid, 1'b0);
    chk("t3_empty", buf_empty, 1'b1);

    // Over-long packet is truncated to 47 words
    send_pkt(20, 60);
    chk("t4_drop", drop_cnt, 16'h2);
    wait_req("t4");
    grant("t4", 1);
    words("t4", 20, 0, 47);
    chk("t4_end", bus.data_out_valid, 1'b0);
    step();
    chk("t4_empty", buf_empty, 1'b1);

    // Reset in the middle of a burst
    send_pkt(30, 47);
    wait_req("t5");
    grant("t5", 1);
    words("t5", 30, 0, 20);
    chk("t5_word20", {bus.data_out_valid, bus.data_out}, {1'b1, wd(30, 20)});
    reset = 1'b0;
    step();
    chk("t5_valid", bus.data_out_valid, 1'b0);
    chk("t5_data", bus.data_out, 33'h0);
    chk("t5_empty", buf_empty, 1'b1);
    chk("t5_drop", drop_cnt, 16'h0);
    // A run that straddles reset release is dropped silently
    bus.data_in_valid = 1'b1;
    bus.data_in       = wd(50, 0);
    step();
    reset = 1'b1;
    for (int k = 1; k < 11; k++) begin
      bus.data_in = wd(50, k);
      step();
    end
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.data_out_valid === 1'b1) hits++;
    end
    chk("t5_silent", 64'(hits), 64'd0);
    chk("t5_straddle_empty", buf_empty, 1'b1);
    chk("t5_straddle_drop", drop_cnt, 16'h0);

    // Stray grants in IDLE and SEND are ignored
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
    step();
    chk("t6_idle_ack", {buf_empty, bus.data_out_valid}, 2'b10);
    send_pkt(40, 47);
    wait_req("t6");
    grant("t6", 2);
    words("t6", 40, 0, 10);
    bus.rd_ack = 1'b1;
    words("t6", 40, 10, 11);
    bus.rd_ack = 1'b0;
    words("t6", 40, 11, 47);
    chk("t6_end", bus.data_out_valid, 1'b0);
    step();
    chk("t6_empty", buf_empty, 1'b1);
    chk("t6_drop", drop_cnt, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
